// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg -- EX/MEM pipeline register of the five-stage MIPS core.
//
// Captures the EX stage result on each rising clock edge and presents it to
// the MEM stage one cycle later. It also carries the partial HI/LO product
// and step count of a two-cycle MADD/MSUB back to EX, so that the operation
// survives a bubble.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous, active-low reset; clears every output
//   stall_i[1:0]        bit0 = EX stalled, bit1 = MEM stalled
//   flush_i             exception flush; discards the in-flight instruction
//   ex_wd_i/ex_wreg_i/ex_wdata_i         destination, write enable, result
//   ex_hi_i/ex_lo_i/ex_whilo_i           HI/LO data and HI/LO write enable
//   ex_aluop_i/ex_mem_addr_i/ex_reg2_i   memory-op code, address, store data
//   hilo_temp_i/cnt_i                    MADD/MSUB partial product and step
//   mem_*_o             registered copies of the ex_*_i fields, for MEM
//   hilo_temp_o/cnt_o   registered partial product and step count, for EX
//
// Update rule per edge, highest priority first:
//   flush    everything loads zero
//   bubble   (stall 01) MEM fields become a NOP, MADD state is carried
//   advance  (stall 00) MEM fields load from EX, MADD state is cleared
//   hold     (stall 1x) everything keeps its value; 10 cannot come from
//            control and is treated as hold
// ---------------------------------------------------------------------------
module ex_mem_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  stall_i,
  input  logic        flush_i,

  input  logic [4:0]  ex_wd_i,
  input  logic        ex_wreg_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [31:0] ex_hi_i,
  input  logic [31:0] ex_lo_i,
  input  logic        ex_whilo_i,
  input  logic [7:0]  ex_aluop_i,
  input  logic [31:0] ex_mem_addr_i,
  input  logic [31:0] ex_reg2_i,
  input  logic [63:0] hilo_temp_i,
  input  logic [1:0]  cnt_i,

  output logic [4:0]  mem_wd_o,
  output logic        mem_wreg_o,
  output logic [31:0] mem_wdata_o,
  output logic [31:0] mem_hi_o,
  output logic [31:0] mem_lo_o,
  output logic        mem_whilo_o,
  output logic [7:0]  mem_aluop_o,
  output logic [31:0] mem_mem_addr_o,
  output logic [31:0] mem_reg2_o,
  output logic [63:0] hilo_temp_o,
  output logic [1:0]  cnt_o
);

  localparam logic [7:0] EXE_NOP_OP = 8'h00;

  typedef enum logic [1:0] {
    UPD_HOLD    = 2'd0,
    UPD_ADVANCE = 2'd1,
    UPD_BUBBLE  = 2'd2,
    UPD_FLUSH   = 2'd3
  } upd_e;

  upd_e upd;

  // Registered state, one stage past EX
  logic [4:0]  wd_p1;
  logic        wreg_p1;
  logic [31:0] wdata_p1;
  logic [31:0] hi_p1;
  logic [31:0] lo_p1;
  logic        whilo_p1;
  logic [7:0]  aluop_p1;
  logic [31:0] mem_addr_p1;
  logic [31:0] reg2_p1;
  logic [63:0] hilo_temp_p1;
  logic [1:0]  cnt_p1;

  // Select the update applied at the next edge. Only 00 advances; 10 is not
  // produced by control and falls through to hold with 11.
  always_comb begin
    upd = UPD_HOLD;
    if (flush_i) begin
      upd = UPD_FLUSH;
    end else if (stall_i == 2'b01) begin
      upd = UPD_BUBBLE;
    end else if (stall_i == 2'b00) begin
      upd = UPD_ADVANCE;
    end
  end

  // ---- EX -> MEM: writeback fields ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_p1    <= 5'h0;
      wreg_p1  <= 1'b0;
      wdata_p1 <= 32'h0;
    end else begin
      unique case (upd)
        UPD_FLUSH, UPD_BUBBLE: begin
          wd_p1    <= 5'h0;
          wreg_p1  <= 1'b0;
          wdata_p1 <= 32'h0;
        end
        UPD_ADVANCE: begin
          wd_p1    <= ex_wd_i;
          wreg_p1  <= ex_wreg_i;
          wdata_p1 <= ex_wdata_i;
        end
        UPD_HOLD: begin
          wd_p1    <= wd_p1;
          wreg_p1  <= wreg_p1;
          wdata_p1 <= wdata_p1;
        end
      endcase
    end
  end

  // ---- EX -> MEM: HI/LO fields ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_p1    <= 32'h0;
      lo_p1    <= 32'h0;
      whilo_p1 <= 1'b0;
    end else begin
      unique case (upd)
        UPD_FLUSH, UPD_BUBBLE: begin
          hi_p1    <= 32'h0;
          lo_p1    <= 32'h0;
          whilo_p1 <= 1'b0;
        end
        UPD_ADVANCE: begin
          hi_p1    <= ex_hi_i;
          lo_p1    <= ex_lo_i;
          whilo_p1 <= ex_whilo_i;
        end
        UPD_HOLD: begin
          hi_p1    <= hi_p1;
          lo_p1    <= lo_p1;
          whilo_p1 <= whilo_p1;
        end
      endcase
    end
  end

  // ---- EX -> MEM: load/store fields ----
  // A bubble must decode as a NOP in MEM, so the op code goes to EXE_NOP_OP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aluop_p1    <= EXE_NOP_OP;
      mem_addr_p1 <= 32'h0;
      reg2_p1     <= 32'h0;
    end else begin
      unique case (upd)
        UPD_FLUSH, UPD_BUBBLE: begin
          aluop_p1    <= EXE_NOP_OP;
          mem_addr_p1 <= 32'h0;
          reg2_p1     <= 32'h0;
        end
        UPD_ADVANCE: begin
          aluop_p1    <= ex_aluop_i;
          mem_addr_p1 <= ex_mem_addr_i;
          reg2_p1     <= ex_reg2_i;
        end
        UPD_HOLD: begin
          aluop_p1    <= aluop_p1;
          mem_addr_p1 <= mem_addr_p1;
          reg2_p1     <= reg2_p1;
        end
      endcase
    end
  end

  // ---- EX -> EX feedback: MADD/MSUB partial state ----
  // EX stalls itself for the first MADD/MSUB cycle, which appears here as a
  // bubble; the partial product and step count are kept across it. Once the
  // instruction advances the state is spent and returns to zero. The count is
  // stored exactly as EX supplies it, 2'b11 included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hilo_temp_p1 <= 64'h0;
      cnt_p1       <= 2'b00;
    end else begin
      unique case (upd)
        UPD_FLUSH, UPD_ADVANCE: begin
          hilo_temp_p1 <= 64'h0;
          cnt_p1       <= 2'b00;
        end
        UPD_BUBBLE: begin
          hilo_temp_p1 <= hilo_temp_i;
          cnt_p1       <= cnt_i;
        end
        UPD_HOLD: begin
          hilo_temp_p1 <= hilo_temp_p1;
          cnt_p1       <= cnt_p1;
        end
      endcase
    end
  end

  assign mem_wd_o       = wd_p1;
  assign mem_wreg_o     = wreg_p1;
  assign mem_wdata_o    = wdata_p1;
  assign mem_hi_o       = hi_p1;
  assign mem_lo_o       = lo_p1;
  assign mem_whilo_o    = whilo_p1;
  assign mem_aluop_o    = aluop_p1;
  assign mem_mem_addr_o = mem_addr_p1;
  assign mem_reg2_o     = reg2_p1;
  assign hilo_temp_o    = hilo_temp_p1;
  assign cnt_o          = cnt_p1;

endmodule

// File: tb/tb_ex_mem_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_reg -- self-checking bench for ex_mem_reg.
//
// A reference model keeps the expected register contents as one bundle and
// updates it once per edge from the flush/bubble/advance/hold rules. Each
// scenario task drives stimulus and compares the DUT against the model and,
// where the scenario has fixed expected values, against those constants.
// ---------------------------------------------------------------------------
module tb_ex_mem_reg;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [63:0] hilo_temp;
    logic [1:0]  cnt;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  stall;
  logic        flush;
  bundle_t     stim;
  bundle_t     model;
  bundle_t     actual;

  logic [4:0]  mem_wd_o;
  logic        mem_wreg_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_hi_o;
  logic [31:0] mem_lo_o;
  logic        mem_whilo_o;
  logic [7:0]  mem_aluop_o;
  logic [31:0] mem_mem_addr_o;
  logic [31:0] mem_reg2_o;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall),
    .flush_i        (flush),
    .ex_wd_i        (stim.wd),
    .ex_wreg_i      (stim.wreg),
    .ex_wdata_i     (stim.wdata),
    .ex_hi_i        (stim.hi),
    .ex_lo_i        (stim.lo),
    .ex_whilo_i     (stim.whilo),
    .ex_aluop_i     (stim.aluop),
    .ex_mem_addr_i  (stim.addr),
    .ex_reg2_i      (stim.reg2),
    .hilo_temp_i    (stim.hilo_temp),
    .cnt_i          (stim.cnt),
    .mem_wd_o       (mem_wd_o),
    .mem_wreg_o     (mem_wreg_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_hi_o       (mem_hi_o),
    .mem_lo_o       (mem_lo_o),
    .mem_whilo_o    (mem_whilo_o),
    .mem_aluop_o    (mem_aluop_o),
    .mem_mem_addr_o (mem_mem_addr_o),
    .mem_reg2_o     (mem_reg2_o),
    .hilo_temp_o    (hilo_temp_o),
    .cnt_o          (cnt_o)
  );

  assign actual = '{wd: mem_wd_o, wreg: mem_wreg_o, wdata: mem_wdata_o,
                    hi: mem_hi_o, lo: mem_lo_o, whilo: mem_whilo_o,
                    aluop: mem_aluop_o, addr: mem_mem_addr_o,
                    reg2: mem_reg2_o, hilo_temp: hilo_temp_o, cnt: cnt_o};

  // Expected register contents after one edge, from the update rules.
  function automatic bundle_t model_next(bundle_t cur, logic fl,
                                         logic [1:0] st, bundle_t in);
    bundle_t n;
    if (fl) begin
      n = '0;
    end else if (st == 2'b01) begin
      n = '0;                       // NOP: aluop 0, no writes
      n.hilo_temp = in.hilo_temp;
      n.cnt       = in.cnt;
    end else if (st == 2'b00) begin
      n = in;
      n.hilo_temp = 64'h0;
      n.cnt       = 2'b00;
    end else begin
      n = cur;
    end
    return n;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.wd        = 5'($urandom);
    b.wreg      = 1'($urandom);
    b.wdata     = $urandom;
    b.hi        = $urandom;
    b.lo        = $urandom;
    b.whilo     = 1'($urandom);
    b.aluop     = 8'($urandom);
    b.addr      = $urandom;
    b.reg2      = $urandom;
    b.hilo_temp = {$urandom, $urandom};
    b.cnt       = 2'($urandom);
    return b;
  endfunction

  // Apply one rising edge with the current inputs, then settle.
  task automatic step();
    @(posedge clk);
    if (!rst) model = '0;
    else      model = model_next(model, flush, stall, stim);
    #1;
  endtask

  task automatic drive(logic fl, logic [1:0] st, bundle_t in);
    @(negedge clk);
    flush = fl;
    stall = st;
    stim  = in;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    flush = 1'b0;
    stall = 2'b00;
    stim  = rand_bundle();
    model = '0;
    #2;
    checks++;
    if (actual !== bundle_t'(0)) begin
      errors++;
      $display("FAIL reset_async: got %h want 0", actual);
    end
    step();
    checks++;
    if (actual !== bundle_t'(0)) begin
      errors++;
      $display("FAIL reset_held: got %h want 0", actual);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_advance();
    bundle_t in;
    in = rand_bundle();
    in.wd = 5'd3;
    in.wreg = 1'b1;
    in.wdata = 32'h1234_5678;
    in.cnt = 2'b10;
    drive(1'b0, 2'b00, in);
    step();
    checks++;
    if (mem_wd_o !== 5'd3 || mem_wreg_o !== 1'b1 || mem_wdata_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL advance_wb: got wd=%0d wreg=%b wdata=%h want 3 1 12345678",
               mem_wd_o, mem_wreg_o, mem_wdata_o);
    end
    checks++;
    if (hilo_temp_o !== 64'h0 || cnt_o !== 2'b00) begin
      errors++;
      $display("FAIL advance_madd_clear: got %h/%b want 0/00", hilo_temp_o, cnt_o);
    end
    checks++;
    if (actual !== model) begin
      errors++;
      $display("FAIL advance_model: got %h want %h", actual, model);
    end
  endtask

  task automatic test_bubble();
    bundle_t in;
    in = rand_bundle();
    in.wreg = 1'b1;
    in.aluop = 8'h23;
    in.hilo_temp = 64'hA;
    in.cnt = 2'b01;
    drive(1'b0, 2'b01, in);
    step();
    checks++;
    if (mem_wreg_o !== 1'b0 || mem_aluop_o !== 8'h00 || mem_whilo_o !== 1'b0) begin
      errors++;
      $display("FAIL bubble_nop: got wreg=%b aluop=%h whilo=%b want 0 00 0",
               mem_wreg_o, mem_aluop_o, mem_whilo_o);
    end
    checks++;
    if (hilo_temp_o !== 64'hA || cnt_o !== 2'b01) begin
      errors++;
      $display("FAIL bubble_madd_keep: got %h/%b want a/01", hilo_temp_o, cnt_o);
    end
    drive(1'b0, 2'b00, in);
    step();
    checks++;
    if (cnt_o !== 2'b00 || hilo_temp_o !== 64'h0) begin
      errors++;
      $display("FAIL bubble_then_advance: got cnt=%b hilo_temp=%h want 00 0",
               cnt_o, hilo_temp_o);
    end
    // A step count of 3 is carried untouched.
    in.cnt = 2'b11;
    drive(1'b0, 2'b01, in);
    step();
    checks++;
    if (cnt_o !== 2'b11) begin
      errors++;
      $display("FAIL cnt_passthrough: got %b want 11", cnt_o);
    end
  endtask

  task automatic test_hold();
    bundle_t in;
    in = rand_bundle();
    in.wdata = 32'hCAFE;
    drive(1'b0, 2'b00, in);
    step();
    in.wdata = 32'hBEEF;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b11, in);
      step();
      checks++;
      if (mem_wdata_o !== 32'hCAFE || actual !== model) begin
        errors++;
        $display("FAIL hold_%0d: got wdata=%h want cafe (full %h want %h)",
                 i, mem_wdata_o, actual, model);
      end
    end
    // 2'b10 behaves as hold
    drive(1'b0, 2'b10, rand_bundle());
    step();
    checks++;
    if (mem_wdata_o !== 32'hCAFE || actual !== model) begin
      errors++;
      $display("FAIL hold_stall10: got %h want %h", actual, model);
    end
    drive(1'b0, 2'b00, in);
    step();
    checks++;
    if (mem_wdata_o !== 32'hBEEF) begin
      errors++;
      $display("FAIL hold_release: got %h want beef", mem_wdata_o);
    end
  endtask

  task automatic test_flush();
    bundle_t in;
    in = rand_bundle();
    in.wreg = 1'b1;
    in.cnt = 2'b01;
    drive(1'b0, 2'b01, in);          // leave nonzero MADD state
    step();
    drive(1'b0, 2'b00, in);          // and nonzero pipeline fields
    step();
    drive(1'b0, 2'b01, in);
    step();
    checks++;
    if (cnt_o !== 2'b01) begin
      errors++;
      $display("FAIL flush_setup: got cnt=%b want 01", cnt_o);
    end
    drive(1'b1, 2'b11, rand_bundle());
    step();
    checks++;
    if (actual !== bundle_t'(0)) begin
      errors++;
      $display("FAIL flush_priority: got %h want 0", actual);
    end
  endtask

  task automatic test_random();
    logic [1:0] st;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: st = 2'b00;
        4, 5:       st = 2'b01;
        6, 7, 8:    st = 2'b11;
        default:    st = 2'b10;
      endcase
      drive(($urandom_range(0, 15) == 0), st, rand_bundle());
      step();
      checks++;
      if (actual !== model) begin
        errors++;
        $display("FAIL random_%0d: got %h want %h", i, actual, model);
      end
    end
  endtask

  task automatic test_async_reset();
    bundle_t in;
    in = rand_bundle();
    in.wreg = 1'b1;
    drive(1'b0, 2'b00, in);
    step();
    drive(1'b0, 2'b01, in);          // mid-MADD state
    step();
    drive(1'b0, 2'b11, in);          // mid-stall
    #2;
    rst = 1'b0;
    model = '0;
    #1;
    checks++;
    if (actual !== bundle_t'(0)) begin
      errors++;
      $display("FAIL async_reset_immediate: got %h want 0", actual);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b00, rand_bundle());
      step();
      checks++;
      if (actual !== bundle_t'(0)) begin
        errors++;
        $display("FAIL async_reset_held_%0d: got %h want 0", i, actual);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    in = rand_bundle();
    drive(1'b0, 2'b00, in);
    step();
    checks++;
    if (actual !== model || mem_wdata_o !== in.wdata) begin
      errors++;
      $display("FAIL reset_release_advance: got %h want %h", actual, model);
    end
  endtask

  initial begin
    test_reset();
    test_advance();
    test_bubble();
    test_hold();
    test_flush();
    test_random();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
